// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control responder: FSM state
// encoding, stage indices into the valid-bit vector and the default
// performance counter width.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } pipe_state_t;

    localparam int STG_IF_ID  = 0;
    localparam int STG_ID_EX  = 1;
    localparam int STG_EX_MEM = 2;
    localparam int STG_MEM_WB = 3;
    localparam int NUM_STG    = 4;

    localparam int CNT_W_DEFAULT = 32;

endpackage

// File: rtl/pipe_perf_cnt.sv
// Performance counters for the pipeline controller. Each counter wraps
// modulo 2^CNT_W and advances by one on its event strobe.
module pipe_perf_cnt
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             stall_ev,
    input  logic             mwait_ev,
    input  logic             flush_ev,
    input  logic             retire_ev,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_mwait,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_retire
);

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [CNT_W-1:0] cnt_stall_r;
    logic [CNT_W-1:0] cnt_mwait_r;
    logic [CNT_W-1:0] cnt_flush_r;
    logic [CNT_W-1:0] cnt_retire_r;

    // Event counters, one increment per strobed cycle, natural wrap.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_stall_r  <= CNT_ZERO;
            cnt_mwait_r  <= CNT_ZERO;
            cnt_flush_r  <= CNT_ZERO;
            cnt_retire_r <= CNT_ZERO;
        end else begin
            if (stall_ev)  cnt_stall_r  <= cnt_stall_r  + CNT_ONE;
            if (mwait_ev)  cnt_mwait_r  <= cnt_mwait_r  + CNT_ONE;
            if (flush_ev)  cnt_flush_r  <= cnt_flush_r  + CNT_ONE;
            if (retire_ev) cnt_retire_r <= cnt_retire_r + CNT_ONE;
        end
    end

    assign cnt_stall  = cnt_stall_r;
    assign cnt_mwait  = cnt_mwait_r;
    assign cnt_flush  = cnt_flush_r;
    assign cnt_retire = cnt_retire_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control responder for the 5-stage RV32I core. Turns the
// memory wait, load-use stall, halt and EX redirect requests into PC and
// stage-register enable/bubble controls, owns the stage valid bits and
// runs the RUN -> DRAIN -> HALTED stop sequence.
// Optional feature macro: PIPE_CTRL_PERF_CNT_EN (performance counters);
// when undefined the counter ports are tied to zero.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             hz_stall,
    input  logic             ex_redirect,
    input  logic             halt_req,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_bubble,
    output logic             id_ex_bubble,
    output logic             ex_mem_bubble,
    output logic             v_if_id,
    output logic             v_id_ex,
    output logic             v_ex_mem,
    output logic             v_mem_wb,
    output logic             halted,
    output logic [CNT_W-1:0] cnt_stall,
    output logic [CNT_W-1:0] cnt_mwait,
    output logic [CNT_W-1:0] cnt_flush,
    output logic [CNT_W-1:0] cnt_retire
);

    pipe_state_t        state_r;
    pipe_state_t        state_next_s;
    logic [NUM_STG-1:0] v_r;

    logic mwait_s;
    logic stall_s;
    logic halt_s;
    logic redir_s;
    logic pipe_empty_s;

    logic pc_en_s;
    logic pc_sel_s;
    logic if_id_en_s;
    logic id_ex_en_s;
    logic ex_mem_en_s;
    logic mem_wb_en_s;
    logic if_id_bubble_s;
    logic id_ex_bubble_s;
    logic ex_mem_bubble_s;

    // Event qualification; each event masks every lower-priority one.
    always_comb begin
        mwait_s      = mem_req & v_r[STG_EX_MEM] & ~mem_ready;
        stall_s      = hz_stall & v_r[STG_ID_EX] & ~mwait_s;
        halt_s       = halt_req & v_r[STG_ID_EX] & ~mwait_s & ~stall_s &
                       (state_r == RUN);
        redir_s      = ex_redirect & v_r[STG_ID_EX] & ~mwait_s & ~stall_s &
                       ~halt_s;
        pipe_empty_s = (v_r == {NUM_STG{1'b0}});
    end

    // Next-state and stage controls; everything idles unless a state enables it.
    always_comb begin
        state_next_s    = state_r;
        pc_en_s         = 1'b0;
        pc_sel_s        = 1'b0;
        if_id_en_s      = 1'b0;
        id_ex_en_s      = 1'b0;
        ex_mem_en_s     = 1'b0;
        mem_wb_en_s     = 1'b0;
        if_id_bubble_s  = 1'b0;
        id_ex_bubble_s  = 1'b0;
        ex_mem_bubble_s = 1'b0;
        case (state_r)
            RUN: begin
                if (mwait_s) begin
                    state_next_s = RUN;
                end else if (stall_s) begin
                    // Consumer and everything younger hold; EX/MEM takes a bubble.
                    ex_mem_en_s     = 1'b1;
                    ex_mem_bubble_s = 1'b1;
                    mem_wb_en_s     = 1'b1;
                end else if (halt_s) begin
                    // Halt moves on to retire; nothing younger is kept.
                    state_next_s   = DRAIN;
                    if_id_en_s     = 1'b1;
                    if_id_bubble_s = 1'b1;
                    id_ex_en_s     = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    ex_mem_en_s    = 1'b1;
                    mem_wb_en_s    = 1'b1;
                end else if (redir_s) begin
                    // Squash the two wrong-path instructions, load the target.
                    pc_en_s        = 1'b1;
                    pc_sel_s       = 1'b1;
                    if_id_en_s     = 1'b1;
                    if_id_bubble_s = 1'b1;
                    id_ex_en_s     = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    ex_mem_en_s    = 1'b1;
                    mem_wb_en_s    = 1'b1;
                end else begin
                    pc_en_s     = 1'b1;
                    if_id_en_s  = 1'b1;
                    id_ex_en_s  = 1'b1;
                    ex_mem_en_s = 1'b1;
                    mem_wb_en_s = 1'b1;
                end
            end
            DRAIN: begin
                if (mwait_s) begin
                    state_next_s = DRAIN;
                end else begin
                    // Fetch stays off; front stages keep filling with bubbles.
                    if_id_en_s     = 1'b1;
                    if_id_bubble_s = 1'b1;
                    id_ex_en_s     = 1'b1;
                    id_ex_bubble_s = 1'b1;
                    ex_mem_en_s    = 1'b1;
                    mem_wb_en_s    = 1'b1;
                    if (pipe_empty_s) begin
                        state_next_s = HALTED;
                    end else begin
                        state_next_s = DRAIN;
                    end
                end
            end
            HALTED: begin
                state_next_s = HALTED;
            end
            default: begin
                // Unreachable encoding: stop the core rather than run on.
                state_next_s = HALTED;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= RUN;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Valid bits follow their register enables; a bubble clears, a hold keeps.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            v_r <= {NUM_STG{1'b0}};
        end else begin
            if (if_id_en_s)  v_r[STG_IF_ID]  <= ~if_id_bubble_s;
            if (id_ex_en_s)  v_r[STG_ID_EX]  <= v_r[STG_IF_ID] & ~id_ex_bubble_s;
            if (ex_mem_en_s) v_r[STG_EX_MEM] <= v_r[STG_ID_EX] & ~ex_mem_bubble_s;
            if (mem_wb_en_s) v_r[STG_MEM_WB] <= v_r[STG_EX_MEM];
        end
    end

    assign pc_en         = pc_en_s;
    assign pc_sel        = pc_sel_s;
    assign if_id_en      = if_id_en_s;
    assign id_ex_en      = id_ex_en_s;
    assign ex_mem_en     = ex_mem_en_s;
    assign mem_wb_en     = mem_wb_en_s;
    assign if_id_bubble  = if_id_bubble_s;
    assign id_ex_bubble  = id_ex_bubble_s;
    assign ex_mem_bubble = ex_mem_bubble_s;
    assign v_if_id       = v_r[STG_IF_ID];
    assign v_id_ex       = v_r[STG_ID_EX];
    assign v_ex_mem      = v_r[STG_EX_MEM];
    assign v_mem_wb      = v_r[STG_MEM_WB];
    assign halted        = (state_r == HALTED);

`ifdef PIPE_CTRL_PERF_CNT_EN
    logic retire_s;
    assign retire_s = v_r[STG_MEM_WB] & mem_wb_en_s;

    pipe_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk        (clk),
        .rstn       (rstn),
        .stall_ev   (stall_s),
        .mwait_ev   (mwait_s),
        .flush_ev   (redir_s),
        .retire_ev  (retire_s),
        .cnt_stall  (cnt_stall),
        .cnt_mwait  (cnt_mwait),
        .cnt_flush  (cnt_flush),
        .cnt_retire (cnt_retire)
    );
`else
    assign cnt_stall  = {CNT_W{1'b0}};
    assign cnt_mwait  = {CNT_W{1'b0}};
    assign cnt_flush  = {CNT_W{1'b0}};
    assign cnt_retire = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. The reference model tracks the
// instruction occupying each stage (by sequence number) and derives the
// expected controls, valid bits, halt state and event counts from the
// event priority rules. Directed sequences pin the model with literal
// expectations; a randomized phase follows.
module tb_pipe_ctrl;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             rstn;
    logic             hz_stall, ex_redirect, halt_req, mem_req, mem_ready;
    logic             pc_en, pc_sel;
    logic             if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic             if_id_bubble, id_ex_bubble, ex_mem_bubble;
    logic             v_if_id, v_id_ex, v_ex_mem, v_mem_wb;
    logic             halted;
    logic [CNT_W-1:0] cnt_stall, cnt_mwait, cnt_flush, cnt_retire;

    pipe_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rstn(rstn),
        .hz_stall(hz_stall), .ex_redirect(ex_redirect), .halt_req(halt_req),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .pc_sel(pc_sel),
        .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_bubble(if_id_bubble), .id_ex_bubble(id_ex_bubble),
        .ex_mem_bubble(ex_mem_bubble),
        .v_if_id(v_if_id), .v_id_ex(v_id_ex), .v_ex_mem(v_ex_mem),
        .v_mem_wb(v_mem_wb), .halted(halted),
        .cnt_stall(cnt_stall), .cnt_mwait(cnt_mwait),
        .cnt_flush(cnt_flush), .cnt_retire(cnt_retire)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: stage contents (0 = empty), stop state, event counts.
    int          pipe_m[4];
    int          mst_m;      // 0 running, 1 draining, 2 stopped
    int          seq_m;
    logic [31:0] m_stall, m_mwait, m_flush, m_retire;
    bit          chk_en = 1'b0;
    logic [8:0]  snap;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] cexp(input logic [31:0] v);
`ifdef PIPE_CTRL_PERF_CNT_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    // Expected controls {pc_en,pc_sel,en[IF/ID..MEM/WB],bub[IF/ID..EX/MEM]}.
    task automatic model_eval(output logic [8:0] c, output bit mw,
                              output bit st, output bit hl, output bit rd);
        bit full_idex = (pipe_m[1] != 0);
        bit full_exm  = (pipe_m[2] != 0);
        mw = mem_req && full_exm && !mem_ready;
        st = !mw && hz_stall && full_idex;
        hl = !mw && !st && (mst_m == 0) && halt_req && full_idex;
        rd = !mw && !st && !hl && ex_redirect && full_idex;
        if (mst_m == 2 || mw)  c = 9'b0_0_0000_000;
        else if (st)           c = 9'b0_0_0011_001;
        else if (hl)           c = 9'b0_0_1111_110;
        else if (mst_m == 1)   c = 9'b0_0_1111_110;
        else if (rd)           c = 9'b1_1_1111_110;
        else                   c = 9'b1_0_1111_000;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) pipe_m[i] = 0;
        mst_m = 0; seq_m = 1;
        m_stall = 0; m_mwait = 0; m_flush = 0; m_retire = 0;
    endtask

    // Move instructions through the model at a clock edge.
    task automatic model_advance();
        logic [8:0] c;
        bit mw, st, hl, rd, empty;
        model_eval(c, mw, st, hl, rd);
        empty = (pipe_m[0] == 0) && (pipe_m[1] == 0) && (pipe_m[2] == 0) && (pipe_m[3] == 0);
        if (c[3]) begin
            if (pipe_m[3] != 0) m_retire++;
            pipe_m[3] = pipe_m[2];
        end
        if (c[4]) pipe_m[2] = c[0] ? 0 : pipe_m[1];
        if (c[5]) pipe_m[1] = c[1] ? 0 : pipe_m[0];
        if (c[6]) begin
            if (c[2]) pipe_m[0] = 0;
            else begin pipe_m[0] = seq_m; seq_m++; end
        end
        if (st) m_stall++;
        if (mw) m_mwait++;
        if (rd) m_flush++;
        if (mst_m == 0 && hl) mst_m = 1;
        else if (mst_m == 1 && !mw && empty) mst_m = 2;
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [8:0] c;
            bit mw, st, hl, rd;
            model_eval(c, mw, st, hl, rd);
            check("ctrl", {pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                           if_id_bubble, id_ex_bubble, ex_mem_bubble}, c);
            check("valid", {v_mem_wb, v_ex_mem, v_id_ex, v_if_id},
                  {pipe_m[3] != 0, pipe_m[2] != 0, pipe_m[1] != 0, pipe_m[0] != 0});
            check("halted", halted, mst_m == 2);
            check("cnt_stall", cnt_stall, cexp(m_stall));
            check("cnt_mwait", cnt_mwait, cexp(m_mwait));
            check("cnt_flush", cnt_flush, cexp(m_flush));
            check("cnt_retire", cnt_retire, cexp(m_retire));
        end
    end

    // One cycle: drive at edge+1, snapshot controls mid-cycle, advance model.
    task automatic step(input bit hz, input bit rd, input bit hr,
                        input bit mq, input bit mr);
        hz_stall = hz; ex_redirect = rd; halt_req = hr; mem_req = mq; mem_ready = mr;
        #4;
        snap = {pc_en, pc_sel, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                if_id_bubble, id_ex_bubble, ex_mem_bubble};
        @(posedge clk);
        if (rstn) model_advance();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        model_reset();
        hz_stall = 1'b0; ex_redirect = 1'b0; halt_req = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    logic [3:0] fill_exp [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

    initial begin
        int stop_cycles;
        rstn = 1'b0;
        hz_stall = 1'b0; ex_redirect = 1'b0; halt_req = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b0;
        model_reset();
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("rst_valid", {v_mem_wb, v_ex_mem, v_id_ex, v_if_id}, 4'b0000);
        check("rst_halted", halted, 1'b0);
        check("rst_cnt_retire", cnt_retire, 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;

        // Fill after reset release, one stage per edge.
        for (int k = 0; k < 4; k++) begin
            idle(1);
            check("fill_valid", {v_mem_wb, v_ex_mem, v_id_ex, v_if_id}, fill_exp[k]);
        end
        idle(1);
        check("first_retire", cnt_retire, cexp(32'd1));

        // Two-cycle load-use stall.
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check("stall_pc_en", snap[8], 1'b0);
            check("stall_exm_bubble", snap[0], 1'b1);
        end
        check("stall_v_ex_mem", v_ex_mem, 1'b0);
        check("stall_count", cnt_stall, cexp(32'd2));

        // Redirect masked by a stall, then taken.
        step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        check("masked_pc_sel", snap[7], 1'b0);
        check("masked_pc_en", snap[8], 1'b0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check("redir_pc_sel", snap[7], 1'b1);
        check("redir_flush_v", {v_id_ex, v_if_id}, 2'b00);
        check("flush_count", cnt_flush, cexp(32'd1));
        idle(1);
        check("target_fetch", v_if_id, 1'b1);
        idle(3);

        // Three memory-wait cycles with a concurrent stall request.
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
            check("mwait_freeze", snap, 9'd0);
        end
        check("mwait_valid", {v_mem_wb, v_ex_mem, v_id_ex, v_if_id}, 4'b1111);
        check("mwait_count", cnt_mwait, cexp(32'd3));
        check("mwait_no_stall", cnt_stall, cexp(32'd3));
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Halt on a full pipe: stopped from edge t+4.
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("halt_pc_en", snap[8], 1'b0);
        check("halt_front_v", {v_id_ex, v_if_id}, 2'b00);
        check("halt_t1", halted, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            idle(1);
            check("drain_pc_en", snap[8], 1'b0);
            check("halt_latency", halted, k == 4);
        end
        check("halt_retired", cnt_retire, cexp(32'd8));

        // Halt with one memory-wait cycle: stopped from edge t+5.
        do_reset();
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("halt2_t1", halted, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("halt2_freeze", snap, 9'd0);
        for (int k = 3; k <= 5; k++) begin
            idle(1);
            check("halt2_latency", halted, k == 5);
        end

        // Asynchronous reset while draining.
        do_reset();
        idle(4);
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1);
        check("drain_occupied", v_mem_wb, 1'b1);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check("async_valid", {v_mem_wb, v_ex_mem, v_id_ex, v_if_id}, 4'b0000);
        check("async_halted", halted, 1'b0);
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(1);
        check("restart_fetch", v_if_id, 1'b1);

        // Randomized phase; restart the core some cycles after it stops.
        stop_cycles = 0;
        for (int i = 0; i < 2500; i++) begin
            if (mst_m == 2) stop_cycles++;
            else stop_cycles = 0;
            if (stop_cycles > 3) begin
                do_reset();
                stop_cycles = 0;
            end else begin
                step($urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
                     $urandom_range(0, 59) == 0, $urandom_range(0, 4) < 2,
                     $urandom_range(0, 4) < 3);
            end
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control responder for the 5-stage RV32I core. It consumes the load-use stall request from the hazard detector, the EX-stage branch/jump redirect, the data-memory handshake and the halt request. From these it drives the PC and every pipeline register with enable and bubble controls, and it holds the authoritative valid bit of each stage. A drain/halt state machine stops the core cleanly on ecall/ebreak.

## Interface
Parameters:
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rstn  in  1  asynchronous, active-low reset
- hz_stall  in  1  load-use stall (consumer in ID/EX, load in EX/MEM)
- ex_redirect  in  1  branch taken or jump resolved in ID/EX (EX) stage
- halt_req  in  1  ecall/ebreak occupying ID/EX
- mem_req  in  1  EX/MEM instruction accesses data memory
- mem_ready  in  1  data memory completes the access this cycle
- pc_en  out  1  PC register load enable
- pc_sel  out  1  1 = load redirect target, 0 = PC+4
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register load enables
- if_id_bubble, id_ex_bubble, ex_mem_bubble  out  1 each  load NOP and clear valid instead of upstream data
- v_if_id, v_id_ex, v_ex_mem, v_mem_wb  out  1 each  stage valid bits
- halted  out  1  core stopped
- cnt_stall, cnt_mwait, cnt_flush, cnt_retire  out  CNT_W each  performance counters

## Operation
- FSM states:
  - RUN: normal operation.
  - DRAIN: fetch stopped, older instructions complete.
  - HALTED: all enables 0. Only reset exits this state.
- Qualified events, evaluated in this priority order:
  - mwait = mem_req & v_ex_mem & ~mem_ready. Freezes everything: all enables 0, no bubbles, valid bits and state held.
  - stall = hz_stall & v_id_ex & ~mwait. Result: pc_en=0, if_id_en=0, id_ex_en=0, ex_mem_en=1 with ex_mem_bubble=1, mem_wb_en=1.
  - halt = halt_req & v_id_ex & ~mwait & ~stall, in RUN only. Result: next state DRAIN, pc_en=0, if_id_en=1 with if_id_bubble=1, id_ex_en=1 with id_ex_bubble=1, downstream stages advance. The halt instruction itself advances and retires.
  - redir = ex_redirect & v_id_ex & ~mwait & ~stall & ~halt. Result: pc_en=1, pc_sel=1, if_id_bubble=1, id_ex_bubble=1, downstream stages advance.
  - Otherwise all enables are 1, no bubbles, pc_sel=0. In RUN a fetch makes v_if_id=1 at the next edge.
- A redirect held off by a stall is ignored. The ID/EX register holds the branch, and the EX logic re-presents the redirect once the stall clears.
- In DRAIN: pc_en=0, IF/ID and ID/EX load bubbles, mwait is still honoured. When all four valid bits are 0, next state is HALTED.
- Valid bits move with their register enables. A bubble clears the valid bit. A disabled register holds its valid bit.
- All control outputs are combinational from the current state and inputs. Valid bits, state and counters are registers.

## Timing
- Reset values (async, while rstn=0): state RUN, all valid bits 0, halted=0, all counters 0.
- First rising edge after reset release: v_if_id=1.
- Redirect flush penalty: 2 bubbles. The target instruction reaches IF/ID 1 edge after the redirect cycle.
- Load-use stall: 1 cycle per asserted cycle; EX/MEM receives 1 bubble per cycle.
- Halt latency, with halt sampled in cycle t and no mwait: the halt instruction is in MEM/WB after edge t+2 and retires at edge t+3. DRAIN sees the pipeline empty in cycle t+3. halted=1 from edge t+4. Each mwait cycle adds 1 cycle.
- Simultaneous mwait and any other input: only the freeze is applied.

## Configuration
- PIPE_CTRL_PERF_CNT_EN:
  - Defined: four CNT_W counters, each wrapping modulo 2^CNT_W.
    - cnt_stall: increments on stall cycles.
    - cnt_mwait: increments on mwait cycles.
    - cnt_flush: increments on redir events.
    - cnt_retire: increments when v_mem_wb & mem_wb_en.
  - Undefined: counter ports remain and are driven constant 0. No counter flops are generated.

## Structure
- Shared package pipe_ctrl_pkg holds:
  - the FSM state enum (RUN, DRAIN, HALTED)
  - stage index constants
  - the CNT_W default
- One sub-module, pipe_perf_cnt: a single instance holding all four counters. It takes the event strobes as inputs and is instantiated only under PIPE_CTRL_PERF_CNT_EN.

## Test plan
- Reset release, no events, 4 cycles -> valid bits fill 1,1,1,1 in stage order, one per edge; cnt_retire=1 after the 4th edge past the first fetch.
- hz_stall=1 for 2 cycles with v_id_ex=1 -> pc_en=0 and ex_mem_bubble=1 in both cycles; v_ex_mem=0 for 2 edges; cnt_stall=2.
- hz_stall and ex_redirect together for 1 cycle, then ex_redirect alone -> first cycle stall only with pc_sel=0; second cycle pc_sel=1, v_if_id and v_id_ex cleared; cnt_flush=1.
- mem_req=1, mem_ready=0 for 3 cycles, together with hz_stall -> all enables 0 and valid bits constant for 3 cycles; cnt_mwait=3, cnt_stall=0.
- halt_req in cycle t on a full pipe -> state DRAIN at t+1, halted=1 at t+4, pc_en=0 from t onward, and the retire count includes the halt instruction. Repeat with 1 mwait cycle inserted -> halted=1 at t+5.
- Assert rstn=0 mid-DRAIN -> all valid bits and halted go to 0 immediately (asynchronously); after release, fetch restarts in RUN.
